// File: rtl/expr_eval_stream.sv
// Streaming expression recogniser/evaluator: NUM (OP NUM)* '=' with OP in
// {+,-,*}, '*' binding tighter than '+'/'-'. Arithmetic wraps mod 2^WIDTH.
// The running sum is kept as acc + coef*num: acc holds the completed
// additive terms, coef the signed product of the current term so far.
module expr_eval_stream #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_OPND, S_ERR} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, coef_q, num_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             out_q, done_q, err_q;

  logic             is_digit, is_op, is_eq;
  logic [3:0]       dval;
  logic [WIDTH-1:0] num_d, val_d, term_d, acc_op_d;

  // Character classification and the arithmetic candidates for this cycle
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A);
    is_eq    = (in == 8'h3D);
    dval     = in[3:0];
    num_d    = WIDTH'(num_q * WIDTH'(10)) + WIDTH'(dval);
    val_d    = acc_q + WIDTH'(coef_q * num_d);
    term_d   = WIDTH'(coef_q * num_q);
    acc_op_d = acc_q + term_d;
  end

  // Recogniser FSM plus evaluation registers; all outputs registered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      coef_q   <= WIDTH'(1);
      num_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          S_IDLE, S_NUM, S_OPND: begin
            if (is_digit && cnt_q != CW'(MAX_DIGITS)) begin
              num_q    <= num_d;
              cnt_q    <= cnt_q + CW'(1);
              result_q <= val_d;
              state_q  <= S_NUM;
              out_q    <= 1'b1;
            end else if (state_q == S_NUM && is_op) begin
              // result keeps the prefix value shown while in NUM
              num_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_OPND;
              out_q   <= 1'b0;
              if (in == 8'h2A) begin
                coef_q <= term_d;
              end else begin
                acc_q  <= acc_op_d;
                coef_q <= (in == 8'h2D) ? '1 : WIDTH'(1);
              end
            end else if (state_q == S_NUM && is_eq) begin
              // result already holds acc + coef*num, the final value
              done_q  <= 1'b1;
              acc_q   <= '0;
              coef_q  <= WIDTH'(1);
              num_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_IDLE;
              out_q   <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              out_q   <= 1'b0;
            end
          end
          default: begin
            // ERR: only '=' recovers, silently (no done pulse)
            if (is_eq) begin
              state_q <= S_IDLE;
              err_q   <= 1'b0;
              acc_q   <= '0;
              coef_q  <= WIDTH'(1);
              num_q   <= '0;
              cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign out    = out_q;
  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_expr_eval_stream.sv
// Bench for expr_eval_stream: a default instance and a WIDTH=8/MAX_DIGITS=3
// instance share one character stream; each is checked against a token-level
// model that re-evaluates the whole expression with precedence each time.
module tb_expr_eval_stream;

  logic       clk, clr, in_valid;
  logic [7:0] in_c;
  logic       out0, done0, err0, out1, done1, err1;
  logic [15:0] res0;
  logic [7:0]  res1;

  int tests = 0;
  int fails = 0;

  expr_eval_stream #(.WIDTH(16), .MAX_DIGITS(4)) dut0 (
    .clk(clk), .clr(clr), .in(in_c), .in_valid(in_valid),
    .out(out0), .result(res0), .done(done0), .err(err0));

  expr_eval_stream #(.WIDTH(8), .MAX_DIGITS(3)) dut1 (
    .clk(clk), .clr(clr), .in(in_c), .in_valid(in_valid),
    .out(out1), .result(res1), .done(done1), .err(err1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: operands and operators of the expression typed so far
  longint unsigned nv [2][64];
  byte unsigned    ov [2][64];
  int              nn [2];
  int              md [2];   // 0 expect-first, 1 in-number, 2 after-op, 3 error
  int              dc [2];
  longint unsigned mres [2];
  logic            mout [2], mdone [2], merr [2];

  function automatic int wid(int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic int maxd(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic longint unsigned meval(int k);
    longint unsigned tot, prod;
    byte unsigned sgn;
    tot = 0;
    sgn = 8'h2B;
    prod = nv[k][0];
    for (int i = 0; i < nn[k] - 1; i++) begin
      if (ov[k][i] == 8'h2A) prod = prod * nv[k][i+1];
      else begin
        tot  = (sgn == 8'h2D) ? tot - prod : tot + prod;
        sgn  = ov[k][i];
        prod = nv[k][i+1];
      end
    end
    tot = (sgn == 8'h2D) ? tot - prod : tot + prod;
    return tot & ((64'd1 << wid(k)) - 64'd1);
  endfunction

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 0; nn[k] = 0; dc[k] = 0; mres[k] = 0;
      mout[k] = 0; mdone[k] = 0; merr[k] = 0;
    end
  endfunction

  function automatic void mstep(int k, byte unsigned c);
    bit dig, op;
    dig = (c >= 8'h30 && c <= 8'h39);
    op  = (c == 8'h2B || c == 8'h2D || c == 8'h2A);
    mdone[k] = 0;
    if (md[k] == 3) begin
      if (c == 8'h3D) begin md[k] = 0; merr[k] = 0; nn[k] = 0; dc[k] = 0; end
    end else if (dig && md[k] != 1) begin
      nv[k][nn[k]] = longint'(c - 8'h30);
      nn[k]++; dc[k] = 1; md[k] = 1;
      mres[k] = meval(k);
    end else if (dig && dc[k] < maxd(k)) begin
      nv[k][nn[k]-1] = nv[k][nn[k]-1] * 10 + longint'(c - 8'h30);
      dc[k]++;
      mres[k] = meval(k);
    end else if (md[k] == 1 && op) begin
      ov[k][nn[k]-1] = c; md[k] = 2; dc[k] = 0;
    end else if (md[k] == 1 && c == 8'h3D) begin
      mdone[k] = 1; md[k] = 0; nn[k] = 0; dc[k] = 0;
    end else begin
      md[k] = 3; merr[k] = 1;
    end
    mout[k] = (md[k] == 1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkall(string tag);
    chk({tag, "/out0"},  64'(out0),  64'(mout[0]));
    chk({tag, "/res0"},  64'(res0),  mres[0]);
    chk({tag, "/done0"}, 64'(done0), 64'(mdone[0]));
    chk({tag, "/err0"},  64'(err0),  64'(merr[0]));
    chk({tag, "/out1"},  64'(out1),  64'(mout[1]));
    chk({tag, "/res1"},  64'(res1),  mres[1]);
    chk({tag, "/done1"}, 64'(done1), 64'(mdone[1]));
    chk({tag, "/err1"},  64'(err1),  64'(merr[1]));
  endtask

  task automatic send(byte unsigned c);
    in_c = c;
    in_valid = 1'b1;
    @(posedge clk);
    mstep(0, c);
    mstep(1, c);
    #1 chkall($sformatf("chr_%c", c));
  endtask

  task automatic sendstr(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic stall(int n);
    in_valid = 1'b0;
    in_c = 8'h39;
    repeat (n) begin
      @(posedge clk);
      mdone[0] = 0;
      mdone[1] = 0;
      #1 chkall("stall");
    end
  endtask

  task automatic pulse_reset();
    #2 clr = 1'b0;
    #1;
    mreset();
    chkall("async_rst");
    #1 clr = 1'b1;
  endtask

  initial begin
    int r;
    byte unsigned c;
    clr = 1'b0;
    in_c = 8'h00;
    in_valid = 1'b0;
    mreset();
    #12;
    chkall("reset");
    clr = 1'b1;

    // 1: simple sums, out toggles per token
    sendstr("6+9+4");
    chk("t1_res19", 64'(res0), 64'd19);
    chk("t1_out", 64'(out0), 64'd1);

    // 2: async reset mid-expression, then a fresh expression
    sendstr("6+9");
    pulse_reset();
    chk("t2_rst_res", 64'(res0), 64'd0);
    sendstr("6*6=");
    chk("t2_done", 64'(done0), 64'd1);
    chk("t2_res36", 64'(res0), 64'd36);

    // 3: precedence and subtraction wrap
    sendstr("2+3*4=");
    chk("t3_res14", 64'(res0), 64'd14);
    sendstr("12-3*4=");
    chk("t3_res0", 64'(res0), 64'd0);
    sendstr("3-5=");
    chk("t3_fffe", 64'(res0), 64'hFFFE);
    chk("t3_fe", 64'(res1), 64'hFE);

    // 4: syntax error, silent recovery, then a valid expression
    sendstr("2**");
    chk("t4_err", 64'(err0), 64'd1);
    sendstr("7=");
    chk("t4_nodone", 64'(done0), 64'd0);
    chk("t4_errclr", 64'(err0), 64'd0);
    sendstr("5=");
    chk("t4_res5", 64'(res0), 64'd5);

    // 5: digit limit (3 on the narrow instance, 4 on the default)
    sendstr("123");
    chk("t5_res123", 64'(res1), 64'd123);
    sendstr("4");
    chk("t5_err1", 64'(err1), 64'd1);
    chk("t5_res1234", 64'(res0), 64'd1234);
    sendstr("=");

    // 6: wrap on the 8-bit instance with stalls between characters
    send(8'h32); stall(3); send(8'h30); stall(3); send(8'h30); stall(3);
    send(8'h2A); stall(3); send(8'h32); stall(3); send(8'h3D);
    chk("t6_res144", 64'(res1), 64'd144);
    chk("t6_res400", 64'(res0), 64'd400);
    sendstr("=");
    chk("t6_eq_err", 64'(err0), 64'd1);
    sendstr("=+");
    chk("t6_op_err", 64'(err1), 64'd1);
    sendstr("=");

    // Random stream against the model
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 80) begin
        case ($urandom_range(0, 2))
          0: c = 8'h2B;
          1: c = 8'h2D;
          default: c = 8'h2A;
        endcase
      end else if (r < 92) c = 8'h3D;
      else begin
        case ($urandom_range(0, 2))
          0: c = 8'h20;
          1: c = 8'h61;
          default: c = 8'h2F;
        endcase
      end
      if (nn[0] >= 50 || nn[1] >= 50) c = 8'h3D;
      send(c);
      if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 2));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
